imem_port_arbiter: RTL and testbench
====================================

IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

Interface
REQ-001 Parameter MEM_DEPTH, default 256: instruction memory depth in 32-bit words.
REQ-002 Parameter MAX_WAIT, default 4: consecutive denied fetch cycles before the fetch port is forced a grant.
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 Fetch_Req  input  1  fetch stage requests a read this cycle.
REQ-006 Fetch_Addr  input  32  byte address of the instruction.
REQ-007 Fetch_Gnt  output  1  fetch read issued to memory this cycle.
REQ-008 Fetch_Valid  output  1  Fetch_Instr holds the data of last cycle's granted read.
REQ-009 Fetch_Instr  output  32  returned instruction word.
REQ-010 Load_Req  input  1  program loader requests a word write.
REQ-011 Load_Addr  input  32  byte address of the write.
REQ-012 Load_Data  input  32  write data.
REQ-013 Load_Gnt  output  1  loader write issued this cycle.
REQ-014 Load_Done  input  1  single-cycle pulse: program image complete.
REQ-015 Boot_Done  output  1  high once in RUN state.
REQ-016 Mem_Addr  output  log2(MEM_DEPTH)  word index to the single-port memory.
REQ-017 Mem_WE  output  1  memory write enable.
REQ-018 Mem_WData  output  32  memory write data.
REQ-019 Mem_RData  input  32  memory read data, registered, valid one cycle after a read issue.

Function
REQ-020 FSM states: BOOT (reset state), RUN; no other states.
REQ-021 BOOT: only the loader is served; Fetch_Gnt held 0 regardless of Fetch_Req.
REQ-022 BOOT -> RUN on the cycle after Load_Done=1 is sampled; a Load_Req in that same cycle is still granted.
REQ-023 RUN is left only by reset; Load_Done is ignored in RUN.
REQ-024 RUN arbitration, one grant per cycle: loader wins over fetch, except when the starvation counter equals MAX_WAIT, in which case fetch wins.
REQ-025 Starvation counter: increments, saturating at MAX_WAIT, on each RUN cycle with Fetch_Req=1 and Fetch_Gnt=0; clears to 0 on Fetch_Gnt=1 or Fetch_Req=0.
REQ-026 Grants are combinational from the current inputs and state; Mem_Addr/Mem_WE/Mem_WData are driven in the grant cycle.
REQ-027 Word index = address[log2(MEM_DEPTH)+1:2]; address bits [1:0] are ignored.
REQ-028 Out of range means any address bit above log2(MEM_DEPTH)+1 is set.
REQ-029 Loader write out of range: Load_Gnt=1 and Mem_WE=0 (write dropped).
REQ-030 Fetch out of range: Fetch_Gnt=1 and no memory read; next cycle Fetch_Valid=1 and Fetch_Instr=32'h00000013 (NOP).
REQ-031 Read latency is exactly 1: Fetch_Valid=1 in cycle N+1 iff Fetch_Gnt=1 in cycle N.
REQ-032 Fetch_Instr = Mem_RData (or the NOP of REQ-030) while Fetch_Valid=1; it is held at its last value otherwise.
REQ-033 With no grant: Mem_WE=0, and Mem_Addr/Mem_WData are don't-care but are driven to 0.
REQ-034 Fetch_Gnt and Load_Gnt are never both 1.

Reset
REQ-035 RST=1 forces asynchronously: state=BOOT, Boot_Done=0, Fetch_Valid=0, Fetch_Instr=0, starvation counter=0, Fetch_Gnt=0, Load_Gnt=0, Mem_WE=0.
REQ-036 A read granted in the cycle reset asserts is discarded; Fetch_Valid is 0 in the first cycle after reset deasserts.

Verification
REQ-037 BOOT write then fetch: Load_Req writes 0x00500093 @0x0; Fetch_Req held -> Fetch_Gnt=0 throughout BOOT; Load_Done pulse -> Boot_Done=1 next cycle; fetch @0x0 -> Fetch_Valid=1, Fetch_Instr=0x00500093 one cycle after grant.
REQ-038 Sequential fetch in RUN: addresses 0x0,0x4,...,0x24 on consecutive cycles with no loader activity -> Fetch_Gnt=1 every cycle and Fetch_Instr matches the preloaded image word for word at 1-cycle latency.
REQ-039 Contention with MAX_WAIT=4: Load_Req and Fetch_Req held high in RUN -> Load_Gnt for 4 cycles, Fetch_Gnt in cycle 5, counter back at 0, then the pattern repeats.
REQ-040 Out of range: fetch @0x400 -> Fetch_Valid=1, Fetch_Instr=0x00000013; loader write @0x400 -> Load_Gnt=1, Mem_WE=0, and memory word 0 unchanged.
REQ-041 Reset mid-operation: RST asserted in the cycle of a fetch grant -> outputs at reset values immediately, no Fetch_Valid after release, state=BOOT.

Source files
------------

// File: rtl/imem_port_arbiter_if.sv
// Fetch, loader and memory signals of the instruction-memory port arbiter.
// slave = arbiter side, master = fetch/loader/memory side.
interface imem_port_arbiter_if #(
  parameter int MEM_DEPTH = 256
);
  localparam int AW = $clog2(MEM_DEPTH);

  logic          Fetch_Req;
  logic [31:0]   Fetch_Addr;
  logic          Fetch_Gnt;
  logic          Fetch_Valid;
  logic [31:0]   Fetch_Instr;

  logic          Load_Req;
  logic [31:0]   Load_Addr;
  logic [31:0]   Load_Data;
  logic          Load_Gnt;
  logic          Load_Done;
  logic          Boot_Done;

  logic [AW-1:0] Mem_Addr;
  logic          Mem_WE;
  logic [31:0]   Mem_WData;
  logic [31:0]   Mem_RData;

  modport slave (
    input  Fetch_Req, Fetch_Addr, Load_Req, Load_Addr, Load_Data, Load_Done, Mem_RData,
    output Fetch_Gnt, Fetch_Valid, Fetch_Instr, Load_Gnt, Boot_Done,
           Mem_Addr, Mem_WE, Mem_WData
  );

  modport master (
    output Fetch_Req, Fetch_Addr, Load_Req, Load_Addr, Load_Data, Load_Done, Mem_RData,
    input  Fetch_Gnt, Fetch_Valid, Fetch_Instr, Load_Gnt, Boot_Done,
           Mem_Addr, Mem_WE, Mem_WData
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares one single-port instruction memory between the fetch stage and the program loader.
// Grants are combinational; read data returns one cycle after a fetch grant; loader wins unless fetch is starved.
module imem_port_arbiter #(
  parameter int MEM_DEPTH = 256,
  parameter int MAX_WAIT  = 4
) (
  input  logic                CLK,
  input  logic                RST,
  imem_port_arbiter_if.slave  bus
);
  localparam int          AW  = $clog2(MEM_DEPTH);
  localparam int          CW  = $clog2(MAX_WAIT + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {BOOT, RUN} state_t;

  state_t        state_q;
  logic          boot_done_q;
  logic [CW-1:0] starve_q;
  logic [CW-1:0] starve_d;
  logic          vld_q;
  logic          nop_q;
  logic [31:0]   instr_q;
  logic [31:0]   instr_d;

  logic          fetch_oor;
  logic          load_oor;
  logic          fetch_gnt;
  logic          load_gnt;
  logic          starved;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic          unused_addr_bits;

  assign unused_addr_bits = &{1'b0, bus.Fetch_Addr[1:0], bus.Load_Addr[1:0]};

  assign fetch_oor = |bus.Fetch_Addr[31:AW+2];
  assign load_oor  = |bus.Load_Addr[31:AW+2];
  assign starved   = (starve_q == CW'(MAX_WAIT));

  // Grants are suppressed while reset is held so nothing issues in the reset cycle.
  always_comb begin
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    if (!RST) begin
      if (state_q == BOOT) begin
        load_gnt = bus.Load_Req;
      end else begin
        fetch_gnt = bus.Fetch_Req && (!bus.Load_Req || starved);
        load_gnt  = bus.Load_Req && !fetch_gnt;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (load_gnt) begin
      mem_addr  = bus.Load_Addr[AW+1:2];
      mem_we    = !load_oor;
      mem_wdata = bus.Load_Data;
    end else if (fetch_gnt && !fetch_oor) begin
      mem_addr  = bus.Fetch_Addr[AW+1:2];
    end
  end

  always_comb begin
    starve_d = '0;
    if (state_q == RUN && bus.Fetch_Req && !fetch_gnt) begin
      starve_d = starved ? starve_q : starve_q + CW'(1);
    end
  end

  assign instr_d = nop_q ? NOP : bus.Mem_RData;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= BOOT;
      boot_done_q <= 1'b0;
      starve_q    <= '0;
      vld_q       <= 1'b0;
      nop_q       <= 1'b0;
      instr_q     <= '0;
    end else begin
      starve_q <= starve_d;
      vld_q    <= fetch_gnt;
      nop_q    <= fetch_gnt && fetch_oor;
      if (vld_q) begin
        instr_q <= instr_d;
      end
      case (state_q)
        BOOT: begin
          if (bus.Load_Done) begin
            state_q     <= RUN;
            boot_done_q <= 1'b1;
          end
        end
        RUN: begin
          state_q     <= RUN;
          boot_done_q <= 1'b1;
        end
        default: begin
          state_q     <= BOOT;
          boot_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Fetch_Gnt   = fetch_gnt;
  assign bus.Load_Gnt    = load_gnt;
  assign bus.Fetch_Valid = vld_q;
  assign bus.Fetch_Instr = vld_q ? instr_d : instr_q;
  assign bus.Boot_Done   = boot_done_q;
  assign bus.Mem_Addr    = mem_addr;
  assign bus.Mem_WE      = mem_we;
  assign bus.Mem_WData   = mem_wdata;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a registered-read memory model attached.
module tb_imem_port_arbiter;
  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  imem_port_arbiter_if #(.MEM_DEPTH(256)) bus();

  imem_port_arbiter #(.MEM_DEPTH(256), .MAX_WAIT(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  logic [31:0] mem [256];

  always @(posedge CLK) begin
    if (bus.Mem_WE) mem[bus.Mem_Addr] <= bus.Mem_WData;
    bus.Mem_RData <= mem[bus.Mem_Addr];
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_done;
    logic        f_req;
    logic [31:0] f_addr;
    logic        e_fgnt;
    logic        e_lgnt;
    logic        e_we;
    logic [7:0]  e_addr;
    logic        e_vld;
    logic [31:0] e_instr;
    logic        e_boot;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic lr, input logic [31:0] la, input logic [31:0] ld,
                       input logic dn, input logic fr, input logic [31:0] fa);
    bus.Load_Req   = lr;
    bus.Load_Addr  = la;
    bus.Load_Data  = ld;
    bus.Load_Done  = dn;
    bus.Fetch_Req  = fr;
    bus.Fetch_Addr = fa;
  endtask

  logic [31:0] img [10];
  logic        fpat [8];
  logic        epat [8];
  logic        prev_fgnt;
  logic        exp_f;

  initial begin
    checks = 0;
    errors = 0;
    //              lreq  laddr        ldata         done  freq  faddr       fgnt lgnt we  addr  vld instr         boot
    vt[0]  = '{1'b1, 32'h0,   32'h00500093, 1'b0, 1'b1, 32'h0,   1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 32'h0,        1'b0};
    vt[1]  = '{1'b1, 32'h4,   32'h11111111, 1'b0, 1'b1, 32'h0,   1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 32'h0,        1'b0};
    vt[2]  = '{1'b1, 32'h400, 32'hDEADBEEF, 1'b1, 1'b1, 32'h0,   1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 32'h0,        1'b0};
    vt[3]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h0,   1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 32'h0,        1'b1};
    vt[4]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h4,   1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 32'h00500093, 1'b1};
    vt[5]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 32'h11111111, 1'b1};
    vt[6]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 32'h00000013, 1'b1};
    vt[7]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 32'h00000013, 1'b1};
    vt[8]  = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 32'h00000013, 1'b1};
    vt[9]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 32'h00000013, 1'b1};
    vt[10] = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h0,   1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 32'h00000013, 1'b1};
    vt[11] = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 32'h00500093, 1'b1};
    vt[12] = '{1'b1, 32'h8,   32'h22222222, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 32'h00500093, 1'b1};
    vt[13] = '{1'b1, 32'hC,   32'h33333333, 1'b0, 1'b1, 32'h0,   1'b0, 1'b1, 1'b1, 8'd3, 1'b0, 32'h00500093, 1'b1};
    vt[14] = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 32'h00500093, 1'b1};

    for (int i = 0; i < 10; i++) img[i] = 32'h1000_0000 + 32'(i) * 32'h111;
    fpat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    epat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset with both requesters active: nothing may be granted.
    RST = 1'b1;
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    #2;
    chk("rst_fetch_gnt", 32'(bus.Fetch_Gnt), 32'h0);
    chk("rst_load_gnt",  32'(bus.Load_Gnt),  32'h0);
    chk("rst_mem_we",    32'(bus.Mem_WE),    32'h0);
    chk("rst_valid",     32'(bus.Fetch_Valid), 32'h0);
    chk("rst_instr",     bus.Fetch_Instr,    32'h0);
    chk("rst_boot_done", 32'(bus.Boot_Done), 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].ld_req, vt[i].ld_addr, vt[i].ld_data, vt[i].ld_done, vt[i].f_req, vt[i].f_addr);
      #2;
      chk($sformatf("v%0d_fetch_gnt", i), 32'(bus.Fetch_Gnt),   32'(vt[i].e_fgnt));
      chk($sformatf("v%0d_load_gnt", i),  32'(bus.Load_Gnt),    32'(vt[i].e_lgnt));
      chk($sformatf("v%0d_mem_we", i),    32'(bus.Mem_WE),      32'(vt[i].e_we));
      chk($sformatf("v%0d_mem_addr", i),  32'(bus.Mem_Addr),    32'(vt[i].e_addr));
      chk($sformatf("v%0d_valid", i),     32'(bus.Fetch_Valid), 32'(vt[i].e_vld));
      chk($sformatf("v%0d_instr", i),     bus.Fetch_Instr,      vt[i].e_instr);
      chk($sformatf("v%0d_boot_done", i), 32'(bus.Boot_Done),   32'(vt[i].e_boot));
      @(negedge CLK);
    end

    // Load a 10-word image in RUN, then fetch it back sequentially.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(i * 4), img[i], 1'b0, 1'b0, 32'h0);
      #2;
      chk($sformatf("img_load_gnt%0d", i), 32'(bus.Load_Gnt), 32'h1);
      @(negedge CLK);
    end
    for (int i = 0; i <= 10; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, (i < 10), 32'(i * 4));
      #2;
      chk($sformatf("seq_fetch_gnt%0d", i), 32'(bus.Fetch_Gnt), 32'((i < 10) ? 1 : 0));
      if (i > 0) begin
        chk($sformatf("seq_valid%0d", i), 32'(bus.Fetch_Valid), 32'h1);
        chk($sformatf("seq_instr%0d", i), bus.Fetch_Instr, img[i-1]);
      end
      @(negedge CLK);
    end

    // Sustained contention: four loader grants, then a forced fetch grant.
    prev_fgnt = 1'b0;
    for (int c = 0; c < 15; c++) begin
      drive(1'b1, 32'h200, 32'hCAFE0000 + 32'(c), 1'b0, 1'b1, 32'h0);
      exp_f = ((c % 5) == 4);
      #2;
      chk($sformatf("cont_fetch_gnt%0d", c), 32'(bus.Fetch_Gnt), 32'(exp_f));
      chk($sformatf("cont_load_gnt%0d", c),  32'(bus.Load_Gnt),  32'(!exp_f));
      chk($sformatf("cont_valid%0d", c),     32'(bus.Fetch_Valid), 32'(prev_fgnt));
      if (prev_fgnt) chk($sformatf("cont_instr%0d", c), bus.Fetch_Instr, img[0]);
      prev_fgnt = exp_f;
      @(negedge CLK);
    end

    // A cycle without Fetch_Req clears the starvation count.
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 32'h204, 32'h0BAD0000 + 32'(c), 1'b0, fpat[c], 32'h0);
      #2;
      chk($sformatf("clr_fetch_gnt%0d", c), 32'(bus.Fetch_Gnt), 32'(epat[c]));
      chk($sformatf("clr_load_gnt%0d", c),  32'(bus.Load_Gnt),  32'(!epat[c]));
      @(negedge CLK);
    end

    // Reset asserted during a fetch grant.
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h4);
    @(negedge CLK);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h4);
    #2;
    chk("pre_rst_fetch_gnt", 32'(bus.Fetch_Gnt), 32'h1);
    chk("pre_rst_valid",     32'(bus.Fetch_Valid), 32'h1);
    RST = 1'b1;
    #1;
    chk("mid_rst_fetch_gnt", 32'(bus.Fetch_Gnt), 32'h0);
    chk("mid_rst_load_gnt",  32'(bus.Load_Gnt),  32'h0);
    chk("mid_rst_mem_we",    32'(bus.Mem_WE),    32'h0);
    chk("mid_rst_valid",     32'(bus.Fetch_Valid), 32'h0);
    chk("mid_rst_instr",     bus.Fetch_Instr,    32'h0);
    chk("mid_rst_boot_done", 32'(bus.Boot_Done), 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    #2;
    chk("post_rst_valid",     32'(bus.Fetch_Valid), 32'h0);
    chk("post_rst_boot_done", 32'(bus.Boot_Done),   32'h0);
    chk("post_rst_fetch_gnt", 32'(bus.Fetch_Gnt),   32'h0);
    @(negedge CLK);
    #2;
    chk("post_rst_valid2",     32'(bus.Fetch_Valid), 32'h0);
    chk("post_rst_fetch_gnt2", 32'(bus.Fetch_Gnt),   32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
